sdram_arbiter_rr: RTL and testbench

- Parametrised successor to the single-client SDRAM arbiter.
- Gives the SDRAM controller port to the init loader until init completes, then arbitrates NUM_CLIENTS read/write clients (PCM, line buffer, background, sprites, …).
- Uses round-robin arbitration with optional fixed priority for client 0 (audio) and a per-grant burst cap for fairness.
- Sits between the SDRAM controller (ar_* port) and all SDRAM masters.

---
 rtl/sdram_arbiter_rr_if.sv | 49 ++++
 rtl/sdram_arbiter_rr.sv | 152 +++++++++++++++
 tb/tb_sdram_arbiter_rr.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_rr_if.sv
// Bus bundle between the SDRAM arbiter, its masters (init loader + clients) and the controller port.
// The arbiter uses the slave view; the surrounding system/bench uses the master view.
interface sdram_arbiter_rr_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int BE_W        = 2
);
    logic [ADDR_W-1:0]             init_addr;
    logic                          init_we;
    logic [DATA_W-1:0]             init_wrdata;
    logic                          init_done;
    logic                          init_ac;
    logic                          init_busy;

    logic [NUM_CLIENTS-1:0]        cl_req;
    logic [NUM_CLIENTS-1:0]        cl_rd;
    logic [NUM_CLIENTS-1:0]        cl_we;
    logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr;
    logic [NUM_CLIENTS*DATA_W-1:0] cl_wrdata;
    logic [NUM_CLIENTS*BE_W-1:0]   cl_be;
    logic [NUM_CLIENTS-1:0]        cl_grant;
    logic [NUM_CLIENTS-1:0]        cl_ac;
    logic [DATA_W-1:0]             cl_rddata;

    logic [ADDR_W-1:0]             ar_addr;
    logic [BE_W-1:0]               ar_be;
    logic                          ar_read;
    logic                          ar_write;
    logic [DATA_W-1:0]             ar_wrdata;
    logic                          ar_ac;
    logic [DATA_W-1:0]             ar_rddata;

    modport slave (
        input  init_addr, init_we, init_wrdata, init_done,
        input  cl_req, cl_rd, cl_we, cl_addr, cl_wrdata, cl_be,
        input  ar_ac, ar_rddata,
        output init_ac, init_busy, cl_grant, cl_ac, cl_rddata,
        output ar_addr, ar_be, ar_read, ar_write, ar_wrdata
    );

    modport master (
        output init_addr, init_we, init_wrdata, init_done,
        output cl_req, cl_rd, cl_we, cl_addr, cl_wrdata, cl_be,
        output ar_ac, ar_rddata,
        input  init_ac, init_busy, cl_grant, cl_ac, cl_rddata,
        input  ar_addr, ar_be, ar_read, ar_write, ar_wrdata
    );
endinterface

// File: rtl/sdram_arbiter_rr.sv
// Round-robin SDRAM port arbiter: init loader owns the port until init_done, then NUM_CLIENTS
// clients share it with optional client-0 priority and a per-grant burst cap.
module sdram_arbiter_rr #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int BE_W        = 2,
    parameter int MAX_BURST   = 64,
    parameter int PRIO0       = 1
) (
    input  logic              clk,
    input  logic              reset,
    sdram_arbiter_rr_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_CLIENTS);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_OWN, ST_TURN} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    last_addr_q, last_addr_d;

    logic [PTR_W-1:0]       win_idx;
    logic                   win_found;
    int                     scan_idx;
    logic [NUM_CLIENTS-1:0] g_onehot;
    logic [ADDR_W-1:0]      g_addr;
    logic [DATA_W-1:0]      g_wrdata;
    logic [BE_W-1:0]        g_be;
    logic                   g_req, g_rd, g_we;
    logic                   other_req, at_cap;

    // The pointer always holds the index of the current (or most recent) grant holder.
    assign g_onehot  = NUM_CLIENTS'(1) << ptr_q;
    assign g_addr    = bus.cl_addr[int'(ptr_q)*ADDR_W +: ADDR_W];
    assign g_wrdata  = bus.cl_wrdata[int'(ptr_q)*DATA_W +: DATA_W];
    assign g_be      = bus.cl_be[int'(ptr_q)*BE_W +: BE_W];
    assign g_req     = bus.cl_req[ptr_q];
    assign g_rd      = bus.cl_rd[ptr_q];
    assign g_we      = bus.cl_we[ptr_q];
    assign other_req = |(bus.cl_req & ~g_onehot);
    assign at_cap    = (cnt_q == CNT_W'(MAX_BURST - 1));

    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        scan_idx  = 0;
        if (PRIO0 != 0 && bus.cl_req[0]) begin
            win_idx   = '0;
            win_found = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_CLIENTS; k++) begin
                scan_idx = (int'(ptr_q) + k) % NUM_CLIENTS;
                if (!win_found && bus.cl_req[scan_idx]) begin
                    win_idx   = PTR_W'(scan_idx);
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        last_addr_d = last_addr_q;
        case (state_q)
            ST_INIT: begin
                if (bus.init_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (win_found) begin
                    state_d = ST_OWN;
                    ptr_d   = win_idx;
                end
            end
            ST_OWN: begin
                last_addr_d = g_addr;
                if (!g_req) begin
                    state_d = ST_TURN;
                    cnt_d   = '0;
                end else if (bus.ar_ac && at_cap) begin
                    // Cap reached: rotate only if someone else is waiting, else restart the count.
                    cnt_d = '0;
                    if (other_req) state_d = ST_TURN;
                end else if (bus.ar_ac) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TURN: begin
                cnt_d = '0;
                if (win_found) begin
                    state_d = ST_OWN;
                    ptr_d   = win_idx;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        bus.init_ac   = 1'b0;
        bus.cl_grant  = '0;
        bus.cl_ac     = '0;
        bus.ar_addr   = last_addr_q;
        bus.ar_be     = '0;
        bus.ar_read   = 1'b0;
        bus.ar_write  = 1'b0;
        bus.ar_wrdata = '0;
        case (state_q)
            ST_INIT: begin
                bus.ar_addr   = bus.init_addr;
                bus.ar_write  = bus.init_we;
                bus.ar_be     = '1;
                bus.ar_wrdata = bus.init_wrdata;
                bus.init_ac   = bus.ar_ac;
            end
            ST_OWN: begin
                bus.cl_grant  = g_onehot;
                bus.ar_addr   = g_addr;
                bus.ar_be     = g_be;
                bus.ar_wrdata = g_wrdata;
                bus.ar_write  = g_we;
                bus.ar_read   = g_rd & ~g_we;
                bus.cl_ac     = bus.ar_ac ? g_onehot : '0;
            end
            default: ;
        endcase
    end

    assign bus.init_busy = (state_q == ST_INIT);
    assign bus.cl_rddata = bus.ar_rddata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            ptr_q       <= PTR_W'(NUM_CLIENTS - 1);
            cnt_q       <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            last_addr_q <= last_addr_d;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// Directed bench for sdram_arbiter_rr: one DUT with client-0 priority (dut_p), one pure
// round-robin (dut_r), both with MAX_BURST=4 and fed from the same stimulus.
module tb_sdram_arbiter_rr;
    localparam int N  = 4;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0]   init_addr;
    logic            init_we;
    logic [DW-1:0]   init_wrdata;
    logic            init_done;
    logic [N-1:0]    cl_req, cl_rd, cl_we;
    logic [N*AW-1:0] cl_addr;
    logic [N*DW-1:0] cl_wrdata;
    logic [N*BW-1:0] cl_be;
    logic            ar_ac;
    logic [DW-1:0]   ar_rddata;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sdram_arbiter_rr_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) ifp ();
    sdram_arbiter_rr_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) ifr ();

    assign ifp.init_addr = init_addr;   assign ifr.init_addr = init_addr;
    assign ifp.init_we = init_we;       assign ifr.init_we = init_we;
    assign ifp.init_wrdata = init_wrdata; assign ifr.init_wrdata = init_wrdata;
    assign ifp.init_done = init_done;   assign ifr.init_done = init_done;
    assign ifp.cl_req = cl_req;         assign ifr.cl_req = cl_req;
    assign ifp.cl_rd = cl_rd;           assign ifr.cl_rd = cl_rd;
    assign ifp.cl_we = cl_we;           assign ifr.cl_we = cl_we;
    assign ifp.cl_addr = cl_addr;       assign ifr.cl_addr = cl_addr;
    assign ifp.cl_wrdata = cl_wrdata;   assign ifr.cl_wrdata = cl_wrdata;
    assign ifp.cl_be = cl_be;           assign ifr.cl_be = cl_be;
    assign ifp.ar_ac = ar_ac;           assign ifr.ar_ac = ar_ac;
    assign ifp.ar_rddata = ar_rddata;   assign ifr.ar_rddata = ar_rddata;

    sdram_arbiter_rr #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW),
                       .MAX_BURST(4), .PRIO0(1)) dut_p (.clk(clk), .reset(reset), .bus(ifp));
    sdram_arbiter_rr #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW),
                       .MAX_BURST(4), .PRIO0(0)) dut_r (.clk(clk), .reset(reset), .bus(ifr));

    function automatic logic [AW-1:0] exp_addr(input int i);
        return AW'(32'h1000 + i * 32'h111);
    endfunction

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later still.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_init();
        tick();
        reset = 1'b1; cl_req = '0; cl_rd = '0; cl_we = '0; ar_ac = 1'b0;
        init_we = 1'b0; init_done = 1'b0;
        tick();
        reset = 1'b0; init_done = 1'b1;
        tick();
        init_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        total++; if (ifp.init_busy !== 1'b1) $display("[TB] FAIL reset_busy: got %b expected 1", ifp.init_busy); else passed++;
        total++; if (ifp.cl_grant !== 4'b0000) $display("[TB] FAIL reset_grant: got %b expected 0000", ifp.cl_grant); else passed++;
        total++; if (ifr.ar_read !== 1'b0) $display("[TB] FAIL reset_read: got %b expected 0", ifr.ar_read); else passed++;
        total++; if (ifr.ar_write !== 1'b0) $display("[TB] FAIL reset_write: got %b expected 0", ifr.ar_write); else passed++;
        total++; if (ifp.ar_be !== 2'b11) $display("[TB] FAIL reset_be: got %b expected 11", ifp.ar_be); else passed++;
    endtask

    task automatic test_init_handoff();
        tick();
        reset = 1'b0; cl_req = 4'b0010; cl_rd = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            init_we = 1'b1; init_addr = AW'(32'h100 + k); init_wrdata = DW'(32'hA000 + k); ar_ac = 1'b1;
            #1;
            total++; if (ifp.init_ac !== 1'b1) $display("[TB] FAIL init_ac[%0d]: got %b expected 1", k, ifp.init_ac); else passed++;
            total++; if (ifp.ar_addr !== AW'(32'h100 + k)) $display("[TB] FAIL init_addr[%0d]: got %h expected %h", k, ifp.ar_addr, 32'h100 + k); else passed++;
            total++; if (ifp.ar_wrdata !== DW'(32'hA000 + k)) $display("[TB] FAIL init_wrdata[%0d]: got %h expected %h", k, ifp.ar_wrdata, 32'hA000 + k); else passed++;
            total++; if (ifp.ar_write !== 1'b1) $display("[TB] FAIL init_write[%0d]: got %b expected 1", k, ifp.ar_write); else passed++;
            total++; if (ifp.cl_ac !== 4'b0000 || ifp.cl_grant !== 4'b0000) $display("[TB] FAIL init_noclient[%0d]: got ac=%b grant=%b expected 0000", k, ifp.cl_ac, ifp.cl_grant); else passed++;
            tick();
        end
        init_we = 1'b0; ar_ac = 1'b0; init_done = 1'b1;
        #1;
        total++; if (ifp.init_ac !== 1'b0) $display("[TB] FAIL init_ac_idle: got %b expected 0", ifp.init_ac); else passed++;
        total++; if (ifp.init_busy !== 1'b1 || ifp.ar_read !== 1'b0) $display("[TB] FAIL init_hold: got busy=%b read=%b expected 1/0", ifp.init_busy, ifp.ar_read); else passed++;
        tick();
        init_done = 1'b0;
        #1;
        total++; if (ifp.init_busy !== 1'b0) $display("[TB] FAIL idle_busy: got %b expected 0", ifp.init_busy); else passed++;
        total++; if (ifp.cl_grant !== 4'b0000) $display("[TB] FAIL idle_grant: got %b expected 0000", ifp.cl_grant); else passed++;
        total++; if (ifp.ar_addr !== '0) $display("[TB] FAIL idle_addr: got %h expected 0", ifp.ar_addr); else passed++;
        tick();
        #1;
        total++; if (ifp.cl_grant !== 4'b0010) $display("[TB] FAIL handoff_grant: got %b expected 0010", ifp.cl_grant); else passed++;
        total++; if (ifp.ar_addr !== exp_addr(1)) $display("[TB] FAIL handoff_addr: got %h expected %h", ifp.ar_addr, exp_addr(1)); else passed++;
        total++; if (ifp.ar_read !== 1'b1) $display("[TB] FAIL handoff_read: got %b expected 1", ifp.ar_read); else passed++;
        cl_req = '0; cl_rd = '0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] oh;
        int g;
        reset_and_init();
        cl_req = 4'b1111; cl_rd = 4'b1111;
        #1;
        total++; if (ifr.cl_grant !== 4'b0000) $display("[TB] FAIL rr_idle_grant: got %b expected 0000", ifr.cl_grant); else passed++;
        tick();
        for (int n = 0; n < 5; n++) begin
            g  = n % N;
            oh = 4'b0001 << g;
            for (int a = 0; a < 2; a++) begin
                ar_ac = 1'b1;
                #1;
                total++; if (ifr.cl_grant !== oh) $display("[TB] FAIL rr_grant[%0d.%0d]: got %b expected %b", n, a, ifr.cl_grant, oh); else passed++;
                total++; if (ifr.cl_ac !== oh) $display("[TB] FAIL rr_ac[%0d.%0d]: got %b expected %b", n, a, ifr.cl_ac, oh); else passed++;
                total++; if (ifr.ar_addr !== exp_addr(g)) $display("[TB] FAIL rr_addr[%0d.%0d]: got %h expected %h", n, a, ifr.ar_addr, exp_addr(g)); else passed++;
                tick();
            end
            ar_ac = 1'b0; cl_req[g] = 1'b0;
            #1;
            total++; if (ifr.cl_grant !== oh) $display("[TB] FAIL rr_drop_grant[%0d]: got %b expected %b", n, ifr.cl_grant, oh); else passed++;
            tick();
            cl_req[g] = 1'b1;
            #1;
            total++; if (ifr.cl_grant !== 4'b0000 || ifr.ar_read !== 1'b0) $display("[TB] FAIL rr_turn[%0d]: got grant=%b read=%b expected 0000/0", n, ifr.cl_grant, ifr.ar_read); else passed++;
            tick();
        end
        cl_req = '0; cl_rd = '0;
    endtask

    task automatic test_priority();
        reset_and_init();
        cl_req = 4'b0100; cl_rd = 4'b0100;
        #1;
        total++; if (ifp.cl_grant !== 4'b0000) $display("[TB] FAIL prio_idle: got %b expected 0000", ifp.cl_grant); else passed++;
        tick();
        cl_req = 4'b1100; cl_rd = 4'b1100;
        #1;
        total++; if (ifp.cl_grant !== 4'b0100) $display("[TB] FAIL prio_own2: got %b expected 0100", ifp.cl_grant); else passed++;
        tick();
        cl_req = 4'b1101; cl_rd = 4'b1101;
        #1;
        total++; if (ifp.cl_grant !== 4'b0100) $display("[TB] FAIL prio_nopreempt: got %b expected 0100", ifp.cl_grant); else passed++;
        tick();
        cl_req = 4'b1001;
        #1;
        total++; if (ifp.cl_grant !== 4'b0100) $display("[TB] FAIL prio_release: got %b expected 0100", ifp.cl_grant); else passed++;
        tick();
        #1;
        total++; if (ifp.cl_grant !== 4'b0000) $display("[TB] FAIL prio_turn: got %b expected 0000", ifp.cl_grant); else passed++;
        tick();
        cl_req = 4'b1000;
        #1;
        total++; if (ifp.cl_grant !== 4'b0001) $display("[TB] FAIL prio_win0: got %b expected 0001", ifp.cl_grant); else passed++;
        total++; if (ifr.cl_grant !== 4'b1000) $display("[TB] FAIL rr_win3: got %b expected 1000", ifr.cl_grant); else passed++;
        tick();
        #1;
        total++; if (ifp.cl_grant !== 4'b0000) $display("[TB] FAIL prio_turn2: got %b expected 0000", ifp.cl_grant); else passed++;
        tick();
        #1;
        total++; if (ifp.cl_grant !== 4'b1000) $display("[TB] FAIL prio_then3: got %b expected 1000", ifp.cl_grant); else passed++;
        cl_req = '0; cl_rd = '0;
    endtask

    task automatic test_burst_cap();
        reset_and_init();
        cl_req = 4'b1010; cl_rd = 4'b1010; ar_ac = 1'b1;
        #1;
        total++; if (ifr.cl_ac !== 4'b0000) $display("[TB] FAIL cap_idle_ac: got %b expected 0000", ifr.cl_ac); else passed++;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (ifr.cl_grant !== 4'b0010 || ifr.cl_ac !== 4'b0010) $display("[TB] FAIL cap_own1[%0d]: got grant=%b ac=%b expected 0010/0010", k, ifr.cl_grant, ifr.cl_ac); else passed++;
            tick();
        end
        #1;
        total++; if (ifr.cl_grant !== 4'b0000 || ifr.cl_ac !== 4'b0000) $display("[TB] FAIL cap_turn: got grant=%b ac=%b expected 0000/0000", ifr.cl_grant, ifr.cl_ac); else passed++;
        tick();
        #1;
        total++; if (ifr.cl_grant !== 4'b1000 || ifr.cl_ac !== 4'b1000) $display("[TB] FAIL cap_own3: got grant=%b ac=%b expected 1000/1000", ifr.cl_grant, ifr.cl_ac); else passed++;
        reset_and_init();
        cl_req = 4'b0010; cl_rd = 4'b0010; ar_ac = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            #1;
            total++; if (ifp.cl_grant !== 4'b0010 || ifp.cl_ac !== 4'b0010) $display("[TB] FAIL cap_solo[%0d]: got grant=%b ac=%b expected 0010/0010", k, ifp.cl_grant, ifp.cl_ac); else passed++;
            tick();
        end
        ar_ac = 1'b0; cl_req = '0; cl_rd = '0;
    endtask

    task automatic test_simultaneous();
        reset_and_init();
        cl_req = 4'b0001; cl_rd = 4'b0001; cl_we = 4'b0001; ar_rddata = 16'hBEEF;
        tick();
        #1;
        total++; if (ifp.ar_write !== 1'b1 || ifp.ar_read !== 1'b0) $display("[TB] FAIL wr_prio: got write=%b read=%b expected 1/0", ifp.ar_write, ifp.ar_read); else passed++;
        total++; if (ifp.ar_wrdata !== 16'h5A00) $display("[TB] FAIL own_wrdata: got %h expected 5a00", ifp.ar_wrdata); else passed++;
        total++; if (ifp.ar_be !== 2'b10) $display("[TB] FAIL own_be: got %b expected 10", ifp.ar_be); else passed++;
        total++; if (ifp.cl_rddata !== 16'hBEEF) $display("[TB] FAIL rddata: got %h expected beef", ifp.cl_rddata); else passed++;
        tick();
        ar_ac = 1'b1; cl_req = 4'b0000;
        #1;
        total++; if (ifp.cl_ac !== 4'b0001 || ifp.cl_grant !== 4'b0001) $display("[TB] FAIL sim_ack: got ac=%b grant=%b expected 0001/0001", ifp.cl_ac, ifp.cl_grant); else passed++;
        tick();
        #1;
        total++; if (ifp.cl_grant !== 4'b0000 || ifp.cl_ac !== 4'b0000 || ifp.ar_write !== 1'b0) $display("[TB] FAIL sim_turn: got grant=%b ac=%b write=%b expected 0000/0000/0", ifp.cl_grant, ifp.cl_ac, ifp.ar_write); else passed++;
        ar_ac = 1'b0;
        tick();
        #1;
        total++; if (ifp.ar_addr !== exp_addr(0) || ifp.cl_grant !== 4'b0000) $display("[TB] FAIL idle_lastaddr: got addr=%h grant=%b expected %h/0000", ifp.ar_addr, ifp.cl_grant, exp_addr(0)); else passed++;
        cl_rd = '0; cl_we = '0;
    endtask

    task automatic test_reset_mid_burst();
        reset_and_init();
        cl_req = 4'b0100; cl_rd = 4'b0100;
        tick();
        #1;
        total++; if (ifr.ar_read !== 1'b1) $display("[TB] FAIL midrst_pre_read: got %b expected 1", ifr.ar_read); else passed++;
        tick();
        reset = 1'b1;
        tick();
        #1;
        total++; if (ifr.cl_grant !== 4'b0000 || ifp.cl_grant !== 4'b0000) $display("[TB] FAIL midrst_grant: got r=%b p=%b expected 0000", ifr.cl_grant, ifp.cl_grant); else passed++;
        total++; if (ifr.ar_read !== 1'b0 || ifp.ar_read !== 1'b0) $display("[TB] FAIL midrst_read: got r=%b p=%b expected 0", ifr.ar_read, ifp.ar_read); else passed++;
        total++; if (ifr.init_busy !== 1'b1 || ifp.init_busy !== 1'b1) $display("[TB] FAIL midrst_busy: got r=%b p=%b expected 1", ifr.init_busy, ifp.init_busy); else passed++;
        reset = 1'b0; cl_req = '0; cl_rd = '0;
    endtask

    initial begin
        reset = 1'b1; init_addr = '0; init_we = 1'b0; init_wrdata = '0; init_done = 1'b0;
        cl_req = '0; cl_rd = '0; cl_we = '0; ar_ac = 1'b0; ar_rddata = '0;
        cl_be = 8'b01_11_01_10;
        for (int i = 0; i < N; i++) begin
            cl_addr[i*AW +: AW]   = exp_addr(i);
            cl_wrdata[i*DW +: DW] = DW'(32'h5A00 + i);
        end
        test_reset();
        test_init_handoff();
        test_round_robin();
        test_priority();
        test_burst_cap();
        test_simultaneous();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
